hilo_mac_ctrl: RTL

HILO_MAC_CTRL -- requirements
Module: hilo_mac_ctrl

---
 rtl/hilo_mac_ctrl_pkg.sv | 25 ++
 rtl/shift_add_mul32.sv | 39 +++
 rtl/hilo_mac_ctrl.sv | 93 +++++++++
 3 files changed

// File: rtl/hilo_mac_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply-accumulate controller.
package hilo_mac_ctrl_pkg;

  localparam int unsigned MUL_STEPS = 32;

  typedef enum logic [1:0] {
    OpMulu  = 2'b00,
    OpMul   = 2'b01,
    OpMadd  = 2'b10,
    OpMaddu = 2'b11
  } mac_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StCalc = 2'b01,
    StFix  = 2'b10,
    StWb   = 2'b11
  } mac_state_e;

  // Unsigned magnitude; 0x80000000 maps to 2^31 as required.
  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/shift_add_mul32.sv
// Radix-2 shift-add 32x32 unsigned multiplier, one step per enabled cycle.
module shift_add_mul32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        step,
  input  logic [31:0] mag_a,
  input  logic [31:0] mag_b,
  output logic [63:0] product
);

  logic [31:0] mcand_q;
  logic [63:0] prod_q, prod_d;
  logic [32:0] sum;

  // Multiplier sits in the low half and is shifted out as the partial product grows.
  always_comb begin
    sum    = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, mcand_q} : 33'd0);
    prod_d = prod_q;
    if (start) begin
      prod_d = {32'd0, mag_b};
    end else if (step) begin
      prod_d = {sum, prod_q[31:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q <= 32'd0;
      prod_q  <= 64'd0;
    end else begin
      if (start) mcand_q <= mag_a;
      prod_q <= prod_d;
    end
  end

  assign product = prod_q;

endmodule

// File: rtl/hilo_mac_ctrl.sv
// HI/LO multiply/accumulate controller: FSM, sign fix-up and HI/LO accumulation.
module hilo_mac_ctrl
  import hilo_mac_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        hilo_we,
  input  logic [63:0] hilo_wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  mac_state_e  state_q, state_d;
  logic [4:0]  cnt_q;
  logic        sign_q, acc_q, done_q;
  logic [63:0] result_q, hilo_q, hilo_d, product;
  logic        xfer, op_signed, op_acc;

  assign req_ready = (state_q == StIdle);
  assign busy      = ~req_ready;
  assign xfer      = req_valid && req_ready;
  assign op_signed = (mac_op_e'(req_op) == OpMul) || (mac_op_e'(req_op) == OpMadd);
  assign op_acc    = (mac_op_e'(req_op) == OpMadd) || (mac_op_e'(req_op) == OpMaddu);

  shift_add_mul32 u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (xfer),
    .step    (state_q == StCalc),
    .mag_a   (magnitude(op_a, op_signed)),
    .mag_b   (magnitude(op_b, op_signed)),
    .product (product)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (xfer) state_d = StCalc;
      StCalc: if (cnt_q == 5'(MUL_STEPS - 1)) state_d = StFix;
      StFix:  state_d = StWb;
      StWb:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // A direct write in IDLE lands before any accumulate from the same-edge request.
  always_comb begin
    hilo_d = hilo_q;
    if (state_q == StIdle && hilo_we) begin
      hilo_d = hilo_wdata;
    end else if (state_q == StWb) begin
      hilo_d = acc_q ? (hilo_q + result_q) : result_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= 5'd0;
      sign_q   <= 1'b0;
      acc_q    <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 64'd0;
      hilo_q   <= 64'd0;
    end else begin
      state_q <= state_d;
      hilo_q  <= hilo_d;
      done_q  <= (state_q == StWb);
      if (xfer) begin
        cnt_q  <= 5'd0;
        sign_q <= op_signed && (op_a[31] ^ op_b[31]);
        acc_q  <= op_acc;
      end else if (state_q == StCalc) begin
        cnt_q <= cnt_q + 5'd1;
      end
      if (state_q == StFix) begin
        result_q <= sign_q ? (~product + 64'd1) : product;
      end
    end
  end

  assign done = done_q;
  assign hi   = hilo_q[63:32];
  assign lo   = hilo_q[31:0];

endmodule
